movement_ctrl: RTL

- Parametrised per-sprite movement controller.
- On each rising edge of the frame tick it erases the sprite at its old position, reads the direction keys, and updates the X/Y position with step size and edge clamping.
- It then redraws the sprite at the new position.
- Sits between the board keys / frame-rate divider and the sprite drawing engine, and talks to the drawing engine through a req/done handshake.

---
 rtl/movement_ctrl_if.sv | 29 ++
 rtl/movement_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/movement_ctrl_if.sv
// Handshake bundle between the movement controller and the sprite drawing engine.
// The controller drives the request, the erase/draw flag and the sprite
// position; the drawing engine answers with draw_done.
interface movement_ctrl_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           draw_req;
    logic           draw_clear;
    logic           draw_done;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;

    modport master (
        output draw_req,
        output draw_clear,
        output x_pos,
        output y_pos,
        input  draw_done
    );

    modport slave (
        input  draw_req,
        input  draw_clear,
        input  x_pos,
        input  y_pos,
        output draw_done
    );
endinterface

// File: rtl/movement_ctrl.sv
// Per-sprite movement controller: on each frame-tick rising edge it erases the
// sprite, applies one clamped step from the direction keys and redraws it.
module movement_ctrl #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int STEP   = 4,
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 156,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 116,
    parameter int X_INIT = 80,
    parameter int Y_INIT = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        key_n,
    input  logic              tick,
    movement_ctrl_if.master   draw,
    output logic [3:0]        at_edge,
    output logic              moved,
    output logic              tick_overrun
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CLEAR,
        S_MOVE,
        S_DRAW
    } state_t;

    // One extra bit on the arithmetic so x + STEP can never wrap.
    localparam logic [X_W:0]   X_STEP_E = (X_W+1)'(STEP);
    localparam logic [X_W:0]   X_MIN_E  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]   X_MAX_E  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]   Y_STEP_E = (Y_W+1)'(STEP);
    localparam logic [Y_W:0]   Y_MIN_E  = (Y_W+1)'(Y_MIN);
    localparam logic [Y_W:0]   Y_MAX_E  = (Y_W+1)'(Y_MAX);
    localparam logic [X_W-1:0] X_MIN_P  = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_MAX_P  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MIN_P  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_MAX_P  = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_INIT_P = X_W'(X_INIT);
    localparam logic [Y_W-1:0] Y_INIT_P = Y_W'(Y_INIT);

    state_t         state_reg, state_next;
    logic           draw_req_reg, draw_clear_reg;
    logic           tick_q_reg, pending_reg, overrun_reg;
    logic [X_W-1:0] x_reg, x_next;
    logic [Y_W-1:0] y_reg, y_next;
    logic [X_W:0]   x_wide, x_plus, x_calc;
    logic [Y_W:0]   y_wide, y_plus, y_calc;
    logic           tick_edge, done_seen;
    logic           right, down, up, left;

    assign {left, up, down, right} = ~key_n;
    assign tick_edge = tick & ~tick_q_reg;
    // draw_done only counts while a request is actually outstanding.
    assign done_seen = draw_req_reg & draw.draw_done;

    // State register; request/erase flags are registered from the next state
    // so they line up with the state and are low throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_INIT;
            draw_req_reg   <= 1'b0;
            draw_clear_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            draw_req_reg   <= (state_next == S_INIT) || (state_next == S_CLEAR) ||
                              (state_next == S_DRAW);
            draw_clear_reg <= (state_next == S_CLEAR);
        end
    end

    // Next-state logic for the erase / move / redraw sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:  if (done_seen) state_next = S_IDLE;
            S_IDLE:  if (tick_edge || pending_reg) state_next = S_CLEAR;
            S_CLEAR: if (done_seen) state_next = S_MOVE;
            S_MOVE:  state_next = S_DRAW;
            S_DRAW:  if (done_seen) state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    // Outputs: moved flags a MOVE cycle that really changes the position.
    always_comb begin
        moved = (state_reg == S_MOVE) && ((x_next != x_reg) || (y_next != y_reg));
    end

    // Tick edge capture; edges outside IDLE collapse into a single pending move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q_reg  <= 1'b0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            tick_q_reg <= tick;
            if (state_reg == S_IDLE) begin
                pending_reg <= 1'b0;
            end else if (tick_edge) begin
                pending_reg <= 1'b1;
            end
            if (tick_edge && pending_reg) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Clamped one-step position update; opposite keys on an axis cancel.
    always_comb begin
        x_wide = {1'b0, x_reg};
        y_wide = {1'b0, y_reg};
        x_plus = x_wide + X_STEP_E;
        y_plus = y_wide + Y_STEP_E;
        x_calc = x_wide;
        y_calc = y_wide;
        if (right && !left) begin
            x_calc = (x_plus > X_MAX_E) ? X_MAX_E : x_plus;
        end else if (left && !right) begin
            x_calc = (x_wide < X_MIN_E + X_STEP_E) ? X_MIN_E : x_wide - X_STEP_E;
        end
        if (down && !up) begin
            y_calc = (y_plus > Y_MAX_E) ? Y_MAX_E : y_plus;
        end else if (up && !down) begin
            y_calc = (y_wide < Y_MIN_E + Y_STEP_E) ? Y_MIN_E : y_wide - Y_STEP_E;
        end
    end

    assign x_next = x_calc[X_W-1:0];
    assign y_next = y_calc[Y_W-1:0];

    // Position only changes on leaving MOVE, so it is stable through CLEAR and DRAW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg <= X_INIT_P;
            y_reg <= Y_INIT_P;
        end else if (state_reg == S_MOVE) begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign at_edge = {x_reg == X_MIN_P, y_reg == Y_MIN_P, y_reg == Y_MAX_P, x_reg == X_MAX_P};
    assign tick_overrun   = overrun_reg;
    assign draw.draw_req   = draw_req_reg;
    assign draw.draw_clear = draw_clear_reg;
    assign draw.x_pos      = x_reg;
    assign draw.y_pos      = y_reg;

endmodule
